ifetch_ctrl: RTL
================

Name: ifetch_ctrl

Overview:
Fetch sequencer between the PC register and a variable-latency instruction memory bus with a req/gnt/rvalid handshake. It owns the fetch PC and issues at most one outstanding request. It buffers responses against decode back-pressure and squashes in-flight fetches on branch or exception redirects. Decode consumes its registered output slot.

Parameters:
RESET_PC, 32'hBFC00000, fetch address loaded on reset
ADDR_W, 32, address and PC width
INSTR_W, 32, instruction width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
stall  in  1  decode cannot accept; hold output slot
redirect_valid  in  1  branch/exception redirect, single-cycle pulse
redirect_pc  in  ADDR_W  redirect target
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid; never earlier than the cycle after gnt
imem_rdata  in  INSTR_W  response data
if_valid  out  1  output slot holds an instruction
if_pc  out  ADDR_W  PC of if_instr
if_instr  out  INSTR_W  fetched instruction
busy  out  1  request outstanding (state WAIT or DROP)

Behaviour:
- Reset, asynchronous: pc=RESET_PC; state=REQ; if_valid=0; if_pc=0; if_instr=0; skid empty. imem_req is asserted in the first cycle after reset deasserts.
- consume = if_valid & ~stall.
- State REQ: imem_req=1, imem_addr=pc. On gnt, latch fetch_pc=pc and go to WAIT. Without gnt, stay in REQ; imem_addr may change only because of a redirect.
- State WAIT: imem_req=0. On rvalid:
  - If ~if_valid or consume: load the output slot (if_valid=1, if_pc=fetch_pc, if_instr=rdata), set pc=fetch_pc+4, go to REQ.
  - Otherwise: load the skid, set pc=fetch_pc+4, go to FULL.
- State FULL: imem_req=0. On consume, move skid to the output slot and go to REQ.
- State DROP: imem_req=0. Wait for rvalid, discard the data, go to REQ.
- Output slot with no new load: if_valid clears on consume and holds otherwise. if_pc and if_instr are stable while stall=1.
- Latency: rvalid to if_valid is 1 cycle. Throughput is limited by one outstanding request.
- Redirect has highest priority, over stall and rvalid:
  - Always: if_valid=0, skid cleared, pc={redirect_pc[ADDR_W-1:2],2'b00}.
  - REQ without gnt: stay in REQ; imem_addr shows the new pc next cycle.
  - REQ with gnt: go to DROP.
  - WAIT with rvalid: data discarded, go to REQ.
  - WAIT without rvalid: go to DROP.
  - DROP: pc updated, stay in DROP.
  - FULL: go to REQ.
- Address arithmetic: pc+4 wraps modulo 2^ADDR_W.
- rvalid seen in REQ or FULL is ignored. This covers stale responses after a reset mid-transaction.
- Redirect and stall asserted together: the redirect wins and the slot is emptied.

Optional Feature:
IFETCH_PERF_EN:
- Defined: adds outputs perf_fetched[31:0] and perf_dropped[31:0].
  - perf_fetched increments on each rvalid accepted into the slot or skid.
  - perf_dropped increments on each rvalid discarded (in DROP, or WAIT+redirect).
  - Both counters wrap and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- ifetch_pkg holds:
  - fetch state enum (REQ, WAIT, FULL, DROP, 2-bit encoding);
  - RESET_PC_DEFAULT;
  - INSTR_W/ADDR_W defaults;
  - PC_INCR=4.
- One sub-module, fetch_skid_buf: single entry {pc,instr} with load/unload/flush and a valid flag.
- State machine and output slot stay in ifetch_ctrl.

Test Plan:
- Reset release, gnt same cycle, rvalid 2 cycles later with rdata=32'h24020001, stall=0 -> imem_addr=BFC00000, then if_valid=1, if_pc=BFC00000 next cycle, next imem_addr=BFC00004.
- stall=1 held for 5 cycles across two responses -> slot holds the first instruction, the second goes to the skid, imem_req=0 in FULL. After stall drops, if_pc goes BFC00000 then BFC00004, with no loss or duplication.
- Redirect to 80001003 while in WAIT, rvalid 3 cycles later -> response discarded, if_valid=0 throughout, next imem_addr=80001000.
- Redirect in the same cycle as rvalid in WAIT -> data discarded, REQ next cycle with the redirect address. With IFETCH_PERF_EN, perf_dropped=1.
- Fetch at pc=FFFFFFFC -> next imem_addr=00000000.
- rst asserted mid-WAIT, stale rvalid one cycle after release -> ignored, imem_addr=BFC00000, if_valid stays 0 until the real response.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Fetch state encoding, width defaults, reset vector and PC step.
package ifetch_pkg;

  localparam int          ADDR_W_DEFAULT   = 32;
  localparam int          INSTR_W_DEFAULT  = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;
  localparam int          PC_INCR          = 4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry {pc, instr} skid buffer that holds a response while decode stalls.
// Flush has priority over load, and load has priority over unload.
module fetch_skid_buf #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               unload,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: one outstanding req/gnt/rvalid fetch, registered output slot,
// skid buffer for back-pressure, redirect squash. IFETCH_PERF_EN adds perf counters.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter int                INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               busy
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped
`endif
);

  fetch_state_t       state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [ADDR_W-1:0]  fetch_pc, fetch_pc_nxt;
  logic               consume;
  logic               slot_load_mem, slot_load_skid;
  logic               skid_load, skid_flush;
  logic               skid_valid;
  logic [ADDR_W-1:0]  skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  assign consume   = if_valid & ~stall;
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign busy      = (state == WAIT) || (state == DROP);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    fetch_pc_nxt   = fetch_pc;
    slot_load_mem  = 1'b0;
    slot_load_skid = 1'b0;
    skid_load      = 1'b0;
    skid_flush     = 1'b0;
    if (redirect_valid) begin
      pc_nxt     = redirect_pc & ~ADDR_W'(3);
      skid_flush = 1'b1;
      case (state)
        REQ:     if (imem_gnt) state_nxt = DROP;
        WAIT:    state_nxt = imem_rvalid ? REQ : DROP;
        FULL:    state_nxt = REQ;
        // A response landing with the redirect is already discarded here.
        DROP:    state_nxt = imem_rvalid ? REQ : DROP;
        default: state_nxt = REQ;
      endcase
    end else begin
      case (state)
        REQ: if (imem_gnt) begin
          fetch_pc_nxt = pc;
          state_nxt    = WAIT;
        end
        WAIT: if (imem_rvalid) begin
          pc_nxt = fetch_pc + ADDR_W'(PC_INCR);
          if (!if_valid || consume) begin
            slot_load_mem = 1'b1;
            state_nxt     = REQ;
          end else begin
            skid_load = 1'b1;
            state_nxt = FULL;
          end
        end
        FULL: if (consume) begin
          slot_load_skid = skid_valid;
          state_nxt      = REQ;
        end
        DROP:    if (imem_rvalid) state_nxt = REQ;
        default: state_nxt = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REQ;
      pc       <= RESET_PC;
      fetch_pc <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (slot_load_mem) begin
      if_valid <= 1'b1;
      if_pc    <= fetch_pc;
      if_instr <= imem_rdata;
    end else if (slot_load_skid) begin
      if_valid <= 1'b1;
      if_pc    <= skid_pc;
      if_instr <= skid_instr;
    end else if (consume) begin
      if_valid <= 1'b0;
    end
  end

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .unload    (slot_load_skid),
    .flush     (skid_flush),
    .load_pc   (fetch_pc),
    .load_instr(imem_rdata),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .instr     (skid_instr)
  );

`ifdef IFETCH_PERF_EN
  logic accept_rsp, drop_rsp;
  assign accept_rsp = imem_rvalid && (state == WAIT) && !redirect_valid;
  assign drop_rsp   = imem_rvalid && ((state == DROP) || (state == WAIT && redirect_valid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (accept_rsp) perf_fetched <= perf_fetched + 32'd1;
      if (drop_rsp)   perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

endmodule
